// File: rtl/character_draw_ctrl.sv
// character_draw_ctrl: per-frame sprite sequencer for the 160x120 VGA adapter.
// On start it erases the previous bounding box to the background colour, then
// scans the new box, presenting each pixel to the sprite lookup and forwarding
// the returned colour. The box is anchored at its left/bottom corner and grows
// upward; pixels off the right edge or above row 0 are not plotted.
// Optional build macro CHAR_TRANSPARENT_EN: skip background-coloured sprite
// pixels during DRAW so only the shape itself is written.
module character_draw_ctrl #(
   parameter int         SPRITE_W  = 16,
   parameter int         SPRITE_H  = 32,
   parameter int         SCREEN_W  = 160,
   parameter logic [2:0] BG_COLOUR = 3'b111
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic [7:0] new_x,
   input  logic [6:0] new_y,
   input  logic [2:0] sprite_color,
   output logic [7:0] yasu_x,
   output logic [6:0] yasu_y,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   localparam int CXW = $clog2(SPRITE_W);
   localparam int CYW = $clog2(SPRITE_H);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t         state, state_nxt;
   logic [CXW-1:0] cx;
   logic [CYW-1:0] cy;
   logic [7:0]     old_x;
   logic [6:0]     old_y;
   logic           old_valid;
   logic           last_px;
   logic           accept;
   logic           scan;
   logic [7:0]     base_x;
   logic [6:0]     base_y;
   logic [8:0]     sum_x;
   logic [7:0]     diff_y;
   logic           clip;

   assign last_px = (cx == CXW'(SPRITE_W - 1)) && (cy == CYW'(SPRITE_H - 1));
   assign accept  = (state == IDLE) && start;
   assign scan    = (state == ERASE) || (state == DRAW);

   // State register; reset mid-frame simply drops back to IDLE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state and pixel outputs. Outputs are combinational so the lookup's
   // answer for (vga_x, vga_y) lands in the same cycle it is asked for.
   always_comb begin
      state_nxt  = state;
      base_x     = (state == ERASE) ? old_x : yasu_x;
      base_y     = (state == ERASE) ? old_y : yasu_y;
      sum_x      = {1'b0, base_x} + 9'(cx);
      diff_y     = {1'b0, base_y} - 8'(cy);
      // A negative row difference means cy > base_y (row above the top).
      clip       = (sum_x >= 9'(SCREEN_W)) || diff_y[7];
      vga_x      = sum_x[7:0];
      vga_y      = diff_y[6:0];
      vga_colour = BG_COLOUR;
      plot       = scan && !clip;
      done       = 1'b0;
      case (state)
         IDLE:  if (start) state_nxt = old_valid ? ERASE : DRAW;
         ERASE: if (last_px) state_nxt = DRAW;
         DRAW: begin
            vga_colour = sprite_color;
`ifdef CHAR_TRANSPARENT_EN
            if (sprite_color == BG_COLOUR) plot = 1'b0;
`endif
            if (last_px) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Position latches, scan counters, old-box validity and registered busy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         yasu_x    <= '0;
         yasu_y    <= '0;
         old_x     <= '0;
         old_y     <= '0;
         old_valid <= 1'b0;
         cx        <= '0;
         cy        <= '0;
         busy      <= 1'b0;
      end else begin
         if (accept) begin
            old_x  <= yasu_x;
            old_y  <= yasu_y;
            yasu_x <= new_x;
            yasu_y <= new_y;
         end
         // Power-of-two box: both counters wrap to 0 on the last pixel,
         // so ERASE hands DRAW a fresh origin with no extra cycle.
         if (scan) begin
            cx <= cx + 1'b1;
            if (cx == CXW'(SPRITE_W - 1)) cy <= cy + 1'b1;
         end else begin
            cx <= '0;
            cy <= '0;
         end
         if ((state == DRAW) && last_px) old_valid <= 1'b1;
         busy <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_character_draw_ctrl.sv
// Directed bench for character_draw_ctrl: reset, first/second frames,
// clipping, busy rejection, transparency and reset abort.
module tb_character_draw_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic [7:0] new_x;
   logic [6:0] new_y;
   logic [2:0] sprite_color;
   logic [7:0] yasu_x;
   logic [6:0] yasu_y;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       plot;
   logic       busy;
   logic       done;
   bit         stub_mode;
   int         ncmp = 0;
   int         nerr = 0;

   always #5 clk = ~clk;

   character_draw_ctrl dut (
      .clk(clk), .resetn(resetn), .start(start), .new_x(new_x), .new_y(new_y),
      .sprite_color(sprite_color), .yasu_x(yasu_x), .yasu_y(yasu_y),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .plot(plot), .busy(busy), .done(done)
   );

   // Lookup stub. Mode 0: never background. Mode 1: 23 sprite pixels
   // (16 on the bottom row, 7 on the row above), background elsewhere.
   logic [7:0] rel_x;
   logic [6:0] rel_y;
   always_comb begin
      rel_x = vga_x - yasu_x;
      rel_y = yasu_y - vga_y;
      if (stub_mode == 1'b0)
         sprite_color = vga_x[0] ? 3'b010 : 3'b001;
      else if ((rel_y == 7'd0 && rel_x < 8'd16) || (rel_y == 7'd1 && rel_x < 8'd7))
         sprite_color = 3'b011;
      else
         sprite_color = 3'b111;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Accept one frame and watch it cycle by cycle until done (bounded).
   task automatic run_frame(input string tag, input bit has_erase,
                            input logic [7:0] nx, input logic [6:0] ny,
                            input int poke, input int exp_e, input int exp_d,
                            input int exp_done, input int fx, input int fy,
                            input int lx, input int ly);
      int ne = 0, nd = 0, dcyc = 0, badc = 0, b1 = 0;
      int gx = -1, gy = -1, hx = -1, hy = -1;
      start = 1'b1; new_x = nx; new_y = ny;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 1100 && dcyc == 0; k++) begin
         if (k == poke) begin start = 1'b1; new_x = 8'd0; new_y = 7'd0; end
         else start = 1'b0;
         if (k == 1) b1 = busy;
         if (plot) begin
            if (gx < 0) begin gx = vga_x; gy = vga_y; end
            hx = vga_x; hy = vga_y;
            if (has_erase && k <= 512) begin
               ne++;
               if (vga_colour !== 3'b111) badc++;
            end else begin
               nd++;
               if (vga_colour !== sprite_color) badc++;
            end
         end
         if (done) dcyc = k;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk({tag, " busy_c1"}, b1, 1);
      chk({tag, " erase_plots"}, ne, exp_e);
      chk({tag, " draw_plots"}, nd, exp_d);
      chk({tag, " done_cycle"}, dcyc, exp_done);
      chk({tag, " colour_errs"}, badc, 0);
      chk({tag, " first_x"}, gx, fx);
      chk({tag, " first_y"}, gy, fy);
      chk({tag, " last_x"}, hx, lx);
      chk({tag, " last_y"}, hy, ly);
      chk({tag, " idle_busy"}, busy, 0);
      chk({tag, " yasu_x"}, yasu_x, nx);
      chk({tag, " yasu_y"}, yasu_y, ny);
   endtask

   initial begin
      resetn = 1'b0; start = 1'b0; new_x = '0; new_y = '0; stub_mode = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst plot", plot, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst colour", vga_colour, 3'b111);
      chk("rst vga_x", vga_x, 0);
      chk("rst vga_y", vga_y, 0);
      chk("rst yasu_x", yasu_x, 0);
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("idle outputs", {plot, busy, done, vga_colour}, 6'b000111);
      end

      // First frame: no erase, 512 draw cycles, done at 513.
      run_frame("f1", 1'b0, 8'd40, 7'd60, 0, 0, 512, 513, 40, 60, 55, 29);
      // Second frame: erase old box, then draw new.
      run_frame("f2", 1'b1, 8'd50, 7'd60, 0, 512, 512, 1025, 40, 60, 65, 29);
      // Clipped on right and top: 10 columns x 11 rows.
      run_frame("f3", 1'b1, 8'd150, 7'd10, 0, 512, 110, 1025, 50, 60, 159, 0);
      // Erase of clipped box; start coincident with done is ignored.
      run_frame("f4", 1'b1, 8'd20, 7'd40, 1025, 110, 512, 1025, 150, 10, 35, 9);
      // start during DRAW is ignored.
      run_frame("f5", 1'b1, 8'd60, 7'd50, 700, 512, 512, 1025, 20, 40, 75, 19);

      // Transparency frame.
      stub_mode = 1'b1;
`ifdef CHAR_TRANSPARENT_EN
      run_frame("f6", 1'b1, 8'd30, 7'd50, 0, 512, 23, 1025, 60, 50, 36, 49);
`else
      run_frame("f6", 1'b1, 8'd30, 7'd50, 0, 512, 512, 1025, 60, 50, 45, 19);
`endif
      stub_mode = 1'b0;

      // Reset abort at DRAW cycle 200 (cycle 712 of the frame).
      start = 1'b1; new_x = 8'd70; new_y = 7'd40;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (711) begin @(posedge clk); #1; end
      chk("abort pre plot", plot, 1);
      chk("abort pre busy", busy, 1);
      resetn = 1'b0;
      #1;
      chk("abort plot", plot, 0);
      chk("abort busy", busy, 0);
      chk("abort yasu_x", yasu_x, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      // old_valid cleared by reset: no erase phase.
      run_frame("f7", 1'b0, 8'd5, 7'd100, 0, 0, 512, 513, 5, 100, 20, 69);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
